// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with a hold-time limit.
// One-hot registered grant, always passing through IDLE between owners.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IW      = (N > 1) ? $clog2(N) : 1,
    localparam int HW      = $clog2(MAX_HOLD)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id,
    output logic          preempt
);

    // Two-bit encoding leaves spare codes that recover to IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b01,
        S_GRANT = 2'b10
    } state_t;

    state_t        r_state,   w_state_n;
    logic [N-1:0]  r_gnt,     w_gnt_n;
    logic          r_valid,   w_valid_n;
    logic [IW-1:0] r_id,      w_id_n;
    logic          r_preempt, w_preempt_n;
    logic [IW-1:0] r_ptr,     w_ptr_n;
    logic [HW-1:0] r_hold,    w_hold_n;

    logic          w_found;
    logic [IW-1:0] w_win;
    logic [IW:0]   w_idx;
    logic [IW:0]   w_nxt;
    logic          w_legal;
    logic          w_others;
    logic          w_hold_max;

    assign gnt       = r_gnt;
    assign gnt_valid = r_valid;
    assign gnt_id    = r_id;
    assign preempt   = r_preempt;

    // Scan requests from ptr upward, wrapping, and pick the first set bit.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(N))
                w_idx = w_idx - (IW+1)'(N);
            if (!w_found && req[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IW-1:0];
            end
        end
        w_nxt = {1'b0, w_win} + (IW+1)'(1);
        if (w_nxt >= (IW+1)'(N))
            w_nxt = '0;
    end

    // Grant sanity and contention flags for the current owner.
    always_comb begin
        w_legal = (r_gnt != '0)
               && ((r_gnt & (r_gnt - N'(1))) == '0)
               && r_gnt[r_id];
        w_others   = (req & ~r_gnt) != '0;
        w_hold_max = (r_hold == HW'(MAX_HOLD - 1));
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_n   = r_state;
        w_gnt_n     = r_gnt;
        w_valid_n   = r_valid;
        w_id_n      = r_id;
        w_preempt_n = 1'b0;
        w_ptr_n     = r_ptr;
        w_hold_n    = r_hold;
        case (r_state)
            S_IDLE: begin
                w_gnt_n   = '0;
                w_valid_n = 1'b0;
                w_id_n    = '0;
                w_hold_n  = '0;
                if (w_found) begin
                    w_state_n = S_GRANT;
                    w_gnt_n   = N'(1) << w_win;
                    w_valid_n = 1'b1;
                    w_id_n    = w_win;
                    w_ptr_n   = w_nxt[IW-1:0];
                end
            end
            S_GRANT: begin
                if (!w_legal || !req[r_id] ||
                    (w_hold_max && w_others)) begin
                    w_state_n   = S_IDLE;
                    w_gnt_n     = '0;
                    w_valid_n   = 1'b0;
                    w_id_n      = '0;
                    w_hold_n    = '0;
                    w_preempt_n = w_legal && req[r_id];
                end else if (!w_hold_max) begin
                    w_hold_n = r_hold + HW'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_gnt_n   = '0;
                w_valid_n = 1'b0;
                w_id_n    = '0;
                w_hold_n  = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_preempt <= 1'b0;
            r_ptr     <= '0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_n;
            r_gnt     <= w_gnt_n;
            r_valid   <= w_valid_n;
            r_id      <= w_id_n;
            r_preempt <= w_preempt_n;
            r_ptr     <= w_ptr_n;
            r_hold    <= w_hold_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req   = '0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         preempt;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model: owner index (-1 = none), pointer, cycles owned.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_owned = 0;
    bit m_pre   = 1'b0;

    rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .preempt   (preempt)
    );

    always #5 clock = ~clock;

    task automatic model_step(input bit rst, input logic [N-1:0] r);
        logic [N-1:0] mine;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_owned = 0; m_pre = 1'b0;
            return;
        end
        m_pre = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (m_owner < 0 && r[i]) begin
                    m_owner = i;
                    m_ptr   = (i + 1) % N;
                    m_owned = 1;
                end
            end
        end else begin
            mine = N'(1) << m_owner;
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (m_owned >= MH && (r & ~mine) != 0) begin
                m_owner = -1;
                m_pre   = 1'b1;
            end else begin
                m_owned++;
            end
        end
    endtask

    function automatic logic [N-1:0] m_gnt();
        return (m_owner < 0) ? '0 : N'(1) << m_owner;
    endfunction

    function automatic logic [1:0] m_id();
        return (m_owner < 0) ? 2'd0 : 2'(m_owner);
    endfunction

    task automatic tick(input logic [N-1:0] r, input bit rst);
        req   = r;
        reset = rst;
        @(posedge clock);
        model_step(rst, r);
        #1;
    endtask

    task automatic test_reset();
        tick('0, 1'b1);
        tick('0, 1'b1);
        n_chk++;
        if (gnt !== 4'b0000) begin
            n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt);
        end
        n_chk++;
        if (gnt_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", gnt_valid);
        end
        n_chk++;
        if (gnt_id !== 2'd0) begin
            n_err++; $display("FAIL reset_id: got %0d want 0", gnt_id);
        end
        n_chk++;
        if (preempt !== 1'b0) begin
            n_err++; $display("FAIL reset_preempt: got %b want 0", preempt);
        end
    endtask

    task automatic test_basic();
        for (int c = 0; c < 3; c++) begin
            tick(4'b0001, 1'b0);
            n_chk++;
            if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1
                || preempt !== 1'b0) begin
                n_err++;
                $display("FAIL basic_grant c=%0d: got gnt=%b id=%0d v=%b p=%b want 0001/0/1/0",
                         c, gnt, gnt_id, gnt_valid, preempt);
            end
        end
        tick('0, 1'b0);
        n_chk++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
            n_err++;
            $display("FAIL basic_release: got gnt=%b v=%b p=%b want 0000/0/0",
                     gnt, gnt_valid, preempt);
        end
    endtask

    task automatic test_rotation();
        int ord[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] e;
        tick('0, 1'b1);
        foreach (ord[j]) begin
            e = N'(1) << ord[j];
            tick(4'b1111, 1'b0);
            n_chk++;
            if (gnt !== e || gnt_id !== 2'(ord[j])) begin
                n_err++;
                $display("FAIL rotation_grant j=%0d: got %b/%0d want %b/%0d",
                         j, gnt, gnt_id, e, ord[j]);
            end
            tick(4'b1111, 1'b0);
            n_chk++;
            if (gnt !== e) begin
                n_err++;
                $display("FAIL rotation_hold j=%0d: got %b want %b", j, gnt, e);
            end
            tick(4'b1111 & ~e, 1'b0);
            n_chk++;
            if (gnt !== 4'b0000 || preempt !== 1'b0) begin
                n_err++;
                $display("FAIL rotation_idle j=%0d: got %b p=%b want 0000 p=0",
                         j, gnt, preempt);
            end
        end
    endtask

    task automatic test_preempt();
        logic [N-1:0] e;
        logic         ep;
        tick('0, 1'b1);
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c <= MH; c++) begin
                tick(4'b0011, 1'b0);
                e  = (c == MH) ? 4'b0000 : ((p % 2 == 1) ? 4'b0010 : 4'b0001);
                ep = (c == MH);
                n_chk++;
                if (gnt !== e || preempt !== ep) begin
                    n_err++;
                    $display("FAIL preempt p=%0d c=%0d: got %b/%b want %b/%b",
                             p, c, gnt, preempt, e, ep);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int bad = 0;
        tick('0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            tick(4'b0100, 1'b0);
            if (gnt !== 4'b0100 || preempt !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL saturation_hold: got %0d bad cycles want 0", bad);
        end
        tick(4'b0101, 1'b0);
        n_chk++;
        if (gnt !== 4'b0000 || preempt !== 1'b1) begin
            n_err++;
            $display("FAIL saturation_preempt: got %b/%b want 0000/1", gnt, preempt);
        end
        tick(4'b0101, 1'b0);
        n_chk++;
        if (gnt !== 4'b0001 || preempt !== 1'b0) begin
            n_err++;
            $display("FAIL saturation_next: got %b/%b want 0001/0", gnt, preempt);
        end
    endtask

    task automatic test_wrap();
        tick('0, 1'b1);
        tick(4'b1000, 1'b0);
        n_chk++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_err++;
            $display("FAIL wrap_first: got %b/%0d want 1000/3", gnt, gnt_id);
        end
        tick('0, 1'b0);
        tick(4'b1001, 1'b0);
        n_chk++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            n_err++;
            $display("FAIL wrap_second: got %b/%0d want 0001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_reset_mid();
        tick('0, 1'b1);
        for (int c = 0; c < 6; c++) tick(4'b0010, 1'b0);
        n_chk++;
        if (gnt !== 4'b0010) begin
            n_err++; $display("FAIL midrst_pre: got %b want 0010", gnt);
        end
        tick(4'b0010, 1'b1);
        n_chk++;
        if (gnt !== 4'b0000 || preempt !== 1'b0 || gnt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_drop: got %b/%b/%b want 0000/0/0",
                     gnt, preempt, gnt_valid);
        end
        tick(4'b0110, 1'b0);
        n_chk++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            n_err++;
            $display("FAIL midrst_regrant: got %b/%0d want 0010/1", gnt, gnt_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r = '0;
        bit           rst;
        int           shown = 0;
        tick('0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            tick(r, rst);
            n_chk++;
            if (gnt !== m_gnt() || gnt_id !== m_id()
                || gnt_valid !== (m_owner >= 0) || preempt !== m_pre) begin
                n_err++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random c=%0d req=%b: got %b/%0d/%b/%b want %b/%0d/%b/%b",
                             c, r, gnt, gnt_id, gnt_valid, preempt,
                             m_gnt(), m_id(), (m_owner >= 0), m_pre);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_preempt();
        test_saturation();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
